// File: rtl/mmss_timer_updown.sv
// rtl/mmss_timer_updown.sv - BCD MM:SS up/down timer with pause, lap freeze, preset load and done flag
module mmss_timer_updown #(
    parameter int TICK_DIV = 50000000,
    parameter int MAX_MIN  = 99
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        go,
    input  logic        stop,
    input  logic        mode,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        lap,
    output logic [3:0]  d3,
    output logic [3:0]  d2,
    output logic [3:0]  d1,
    output logic [3:0]  d0,
    output logic        running,
    output logic        lap_active,
    output logic        done,
    output logic        load_err
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    MAX_MT   = 4'(MAX_MIN / 10);
    localparam logic [3:0]    MAX_MO   = 4'(MAX_MIN % 10);
    localparam logic [15:0]   CNT_MAX  = {MAX_MT, MAX_MO, 4'd5, 4'd9};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state, n_state;
    logic [15:0]   r_cnt, n_cnt;
    logic [PW-1:0] r_pre, n_pre;
    logic          r_mode, n_mode;
    logic [15:0]   r_lap, n_lap;
    logic          r_lap_act, n_lap_act;
    logic          n_load_err;
    logic [15:0]   r_disp;
    logic          r_running, r_done, r_load_err;

    logic [15:0]   w_inc, w_dec;
    logic          w_tick, w_term, w_preset_ok, w_load_ok;
    logic [PW-1:0] w_pre_nxt;

    assign w_tick    = (r_state == S_RUN) && (r_pre == PRE_LAST);
    assign w_pre_nxt = (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);

    // Minutes are compared digit-wise in BCD against MAX_MIN.
    assign w_preset_ok = (preset[15:12] <= 4'd9) && (preset[11:8] <= 4'd9) &&
                         (preset[7:4] <= 4'd5) && (preset[3:0] <= 4'd9) &&
                         ((preset[15:12] < MAX_MT) ||
                          ((preset[15:12] == MAX_MT) && (preset[11:8] <= MAX_MO)));
    assign w_load_ok = load && (r_state != S_RUN) && w_preset_ok;

    always_comb begin
        w_inc = r_cnt;
        if (r_cnt[3:0] != 4'd9) begin
            w_inc[3:0] = r_cnt[3:0] + 4'd1;
        end else begin
            w_inc[3:0] = 4'd0;
            if (r_cnt[7:4] != 4'd5) begin
                w_inc[7:4] = r_cnt[7:4] + 4'd1;
            end else begin
                w_inc[7:4] = 4'd0;
                if (r_cnt[11:8] != 4'd9) begin
                    w_inc[11:8] = r_cnt[11:8] + 4'd1;
                end else begin
                    w_inc[11:8]  = 4'd0;
                    w_inc[15:12] = r_cnt[15:12] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_dec = r_cnt;
        if (r_cnt[3:0] != 4'd0) begin
            w_dec[3:0] = r_cnt[3:0] - 4'd1;
        end else begin
            w_dec[3:0] = 4'd9;
            if (r_cnt[7:4] != 4'd0) begin
                w_dec[7:4] = r_cnt[7:4] - 4'd1;
            end else begin
                w_dec[7:4] = 4'd5;
                if (r_cnt[11:8] != 4'd0) begin
                    w_dec[11:8] = r_cnt[11:8] - 4'd1;
                end else begin
                    w_dec[11:8]  = 4'd9;
                    w_dec[15:12] = r_cnt[15:12] - 4'd1;
                end
            end
        end
    end

    // A zero count in down mode is treated as terminal so the borrow never wraps.
    assign w_term = r_mode ? ((w_dec == 16'h0000) || (r_cnt == 16'h0000))
                           : (r_cnt == CNT_MAX);

    always_comb begin
        n_state    = r_state;
        n_cnt      = r_cnt;
        n_pre      = r_pre;
        n_mode     = r_mode;
        n_lap      = r_lap;
        n_lap_act  = r_lap_act;
        n_load_err = 1'b0;
        if (load && (r_state != S_RUN)) begin
            if (w_preset_ok) begin
                n_state   = S_IDLE;
                n_cnt     = preset;
                n_pre     = '0;
                n_lap_act = 1'b0;
            end else begin
                n_load_err = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!stop && go && !(mode && (r_cnt == 16'h0000))) begin
                        n_state = S_RUN;
                        n_mode  = mode;
                    end
                end
                S_RUN: begin
                    if (w_tick && w_term) begin
                        n_state = S_DONE;
                        n_pre   = '0;
                        n_cnt   = r_mode ? 16'h0000 : r_cnt;
                    end else if (stop) begin
                        n_state = S_PAUSE;
                    end else begin
                        n_pre = w_pre_nxt;
                        if (w_tick) begin
                            n_cnt = r_mode ? w_dec : w_inc;
                        end
                    end
                end
                S_PAUSE: begin
                    if (!stop && go) begin
                        n_state = S_RUN;
                    end
                end
                default: ;
            endcase
        end
        if (lap && !w_load_ok) begin
            if (r_lap_act) begin
                n_lap_act = 1'b0;
            end else if (r_state == S_RUN) begin
                n_lap_act = 1'b1;
                n_lap     = r_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'h0000;
            r_pre      <= '0;
            r_mode     <= 1'b0;
            r_lap      <= 16'h0000;
            r_lap_act  <= 1'b0;
            r_disp     <= 16'h0000;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= n_state;
            r_cnt      <= n_cnt;
            r_pre      <= n_pre;
            r_mode     <= n_mode;
            r_lap      <= n_lap;
            r_lap_act  <= n_lap_act;
            r_disp     <= n_lap_act ? n_lap : n_cnt;
            r_running  <= (n_state == S_RUN);
            r_done     <= (n_state == S_DONE);
            r_load_err <= n_load_err;
        end
    end

    assign d3         = r_disp[15:12];
    assign d2         = r_disp[11:8];
    assign d1         = r_disp[7:4];
    assign d0         = r_disp[3:0];
    assign running    = r_running;
    assign lap_active = r_lap_act;
    assign done       = r_done;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_mmss_timer_updown.sv
// tb/tb_mmss_timer_updown.sv - directed self-checking bench for mmss_timer_updown
module tb_mmss_timer_updown;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        go = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic        load = 1'b0;
    logic [15:0] preset = 16'h0000;
    logic        lap = 1'b0;
    logic [3:0]  d3, d2, d1, d0;
    logic        running, lap_active, done, load_err;

    int n_chk  = 0;
    int n_pass = 0;

    mmss_timer_updown #(.TICK_DIV(4), .MAX_MIN(2)) dut (
        .clk        (clk),
        .clr        (clr),
        .go         (go),
        .stop       (stop),
        .mode       (mode),
        .load       (load),
        .preset     (preset),
        .lap        (lap),
        .d3         (d3),
        .d2         (d2),
        .d1         (d1),
        .d0         (d0),
        .running    (running),
        .lap_active (lap_active),
        .done       (done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // flags packed as {running, done, lap_active, load_err}
    task automatic chk_all(input string tag, input logic [15:0] disp, input logic [3:0] flags);
        chk({tag, " disp"}, {16'h0, d3, d2, d1, d0}, {16'h0, disp});
        chk({tag, " flags"}, {28'h0, running, done, lap_active, load_err}, {28'h0, flags});
    endtask

    initial begin
        cyc(2);
        chk_all("reset", 16'h0000, 4'b0000);
        clr = 1'b0;
        cyc(1);
        chk_all("idle", 16'h0000, 4'b0000);

        go = 1'b1; mode = 1'b0;
        cyc(1);
        go = 1'b0;
        chk_all("up start", 16'h0000, 4'b1000);
        cyc(239);
        chk_all("up 00:59", 16'h0059, 4'b1000);
        cyc(1);
        chk_all("up 01:00", 16'h0100, 4'b1000);
        cyc(476);
        chk_all("up 02:59", 16'h0259, 4'b1000);
        cyc(3);
        chk_all("up pre-terminal", 16'h0259, 4'b1000);
        cyc(1);
        chk_all("up saturate", 16'h0259, 4'b0100);
        go = 1'b1;
        cyc(2);
        go = 1'b0;
        chk_all("done ignores go", 16'h0259, 4'b0100);

        load = 1'b1; preset = 16'h0102;
        cyc(1);
        load = 1'b0;
        chk_all("load 01:02", 16'h0102, 4'b0000);
        mode = 1'b1; go = 1'b1;
        cyc(1);
        go = 1'b0; mode = 1'b0;
        chk_all("down start", 16'h0102, 4'b1000);
        cyc(4);
        chk_all("down 01:01", 16'h0101, 4'b1000);
        cyc(240);
        chk_all("down 00:01", 16'h0001, 4'b1000);
        cyc(4);
        chk_all("down done", 16'h0000, 4'b0100);

        load = 1'b1; preset = 16'h0000;
        cyc(1);
        load = 1'b0;
        mode = 1'b1; go = 1'b1;
        cyc(2);
        go = 1'b0; mode = 1'b0;
        chk_all("go ignored at 00:00 down", 16'h0000, 4'b0000);

        go = 1'b1;
        cyc(1);
        go = 1'b0;
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk_all("pause", 16'h0000, 4'b0000);
        cyc(10);
        chk_all("pause hold", 16'h0000, 4'b0000);
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        cyc(1);
        chk_all("resume pre-tick", 16'h0000, 4'b1000);
        cyc(1);
        chk_all("resume tick", 16'h0001, 4'b1000);

        stop = 1'b1; go = 1'b1;
        cyc(1);
        stop = 1'b0; go = 1'b0;
        chk_all("stop+go pause", 16'h0001, 4'b0000);
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        cyc(16);
        chk_all("count 00:05", 16'h0005, 4'b1000);

        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk_all("lap capture", 16'h0005, 4'b1010);
        cyc(11);
        chk_all("lap frozen", 16'h0005, 4'b1010);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk_all("lap release", 16'h0008, 4'b1000);

        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        load = 1'b1; preset = 16'h0170;
        cyc(1);
        load = 1'b0;
        chk_all("bad seconds err", 16'h0008, 4'b0001);
        cyc(1);
        chk_all("err one cycle", 16'h0008, 4'b0000);
        load = 1'b1; preset = 16'h0300;
        cyc(1);
        load = 1'b0;
        chk_all("bad minutes err", 16'h0008, 4'b0001);

        go = 1'b1;
        cyc(1);
        go = 1'b0;
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk_all("lap before clr", 16'h0008, 4'b1010);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk_all("clr mid-run", 16'h0000, 4'b0000);
        cyc(5);
        chk_all("idle after clr", 16'h0000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
